// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_loader
//
// Streaming program loader placed in front of the core's instruction memory.
// It accepts 32-bit words on a valid/ready stream and writes them to IMEM at
// consecutive word-aligned byte addresses. The core is held in reset until the
// image is complete; the core is then released and done/error status reported.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> one trailing checksum word (32-bit sum of the image, mod 2^32)
//                is consumed after the image. A mismatch raises Load_error and
//                returns to IDLE with the core still in reset.
//   undefined -> no checksum word; Load_error only flags an oversize Load_len.
//
// Ports:
//   Clk, Reset_n          clock (rising edge), async active-low reset
//   Load_start, Load_len  load request and image length in words
//   S_valid/S_data/S_ready  input word stream
//   IMEM_wr_en/addr/data  one-cycle IMEM write port (byte address)
//   Core_reset_n          active-low core reset, high only in RUN
//   Load_busy             high in LOAD and CHECK
//   Load_done             high in RUN
//   Load_error            sticky error, cleared by the next accepted Load_start
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int IMEM_DEPTH = 2048,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Load_start,
  input  logic [LEN_WIDTH-1:0] Load_len,
  input  logic                 S_valid,
  input  logic [31:0]          S_data,
  output logic                 S_ready,
  output logic                 IMEM_wr_en,
  output logic [31:0]          IMEM_wr_addr,
  output logic [31:0]          IMEM_wr_data,
  output logic                 Core_reset_n,
  output logic                 Load_busy,
  output logic                 Load_done,
  output logic                 Load_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam logic LP_CHECKSUM = 1'b1;
`else
  localparam logic LP_CHECKSUM = 1'b0;
`endif

  localparam logic [LEN_WIDTH:0]   LP_DEPTH = (LEN_WIDTH+1)'(IMEM_DEPTH);
  localparam logic [LEN_WIDTH-1:0] LP_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next_state;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_s_ready;
  logic                 r_wr_en;
  logic [31:0]          r_wr_addr;
  logic [31:0]          r_wr_data;
  logic                 r_core_rst_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  logic                 w_beat;      // image word accepted this cycle
  logic                 w_accept;    // Load_start accepted this cycle
  logic                 w_err_set;
  logic                 w_last;
  logic                 w_oversize;
  logic [31:0]          w_addr;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0]          r_sum;
`endif

  assign w_last     = (r_cnt == (r_len - LP_ONE));
  assign w_oversize = ({1'b0, Load_len} > LP_DEPTH);
  assign w_addr     = {{(30-LEN_WIDTH){1'b0}}, r_cnt, 2'b00};

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_next_state = r_state;
    w_beat       = 1'b0;
    w_accept     = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (Load_start) begin
          w_accept = 1'b1;
          if (w_oversize) begin
            w_err_set    = 1'b1;
            w_next_state = ST_IDLE;
          end else if (Load_len == '0) begin
            w_next_state = ST_CHECK;
          end else begin
            w_next_state = ST_LOAD;
          end
        end else begin
          w_next_state = r_state;
        end
      end
      ST_LOAD: begin
        w_beat = S_valid & r_s_ready;
        if (w_beat && w_last) begin
          w_next_state = ST_CHECK;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        // Checksum beat: compared only, never written to IMEM.
        if (S_valid && r_s_ready) begin
          if (S_data == r_sum) begin
            w_next_state = ST_RUN;
          end else begin
            w_err_set    = 1'b1;
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_CHECK;
        end
`else
        w_next_state = ST_RUN;
`endif
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; state-derived outputs are
  // decoded from the next state so they line up with the state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_s_ready    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 32'h0000_0000;
      r_wr_data    <= 32'h0000_0000;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_s_ready    <= (w_next_state == ST_LOAD) ||
                      (LP_CHECKSUM && (w_next_state == ST_CHECK));
      r_core_rst_n <= (w_next_state == ST_RUN);
      r_done       <= (w_next_state == ST_RUN);
      r_busy       <= (w_next_state == ST_LOAD) || (w_next_state == ST_CHECK);
      r_wr_en      <= w_beat;
      if (w_beat) begin
        r_wr_addr <= w_addr;
        r_wr_data <= S_data;
      end
      if (w_accept) begin
        r_len <= Load_len;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + LP_ONE;
      end
      // Set wins over clear so an oversize request reports its own error.
      if (w_err_set) begin
        r_error <= 1'b1;
      end else if (w_accept) begin
        r_error <= 1'b0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running 32-bit image sum, wrapping mod 2^32.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sum <= 32'h0000_0000;
    end else if (w_accept) begin
      r_sum <= 32'h0000_0000;
    end else if (w_beat) begin
      r_sum <= r_sum + S_data;
    end
  end
`endif

  assign S_ready      = r_s_ready;
  assign IMEM_wr_en   = r_wr_en;
  assign IMEM_wr_addr = r_wr_addr;
  assign IMEM_wr_data = r_wr_data;
  assign Core_reset_n = r_core_rst_n;
  assign Load_busy    = r_busy;
  assign Load_done    = r_done;
  assign Load_error   = r_error;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Load_start = 1'b0;
  logic [11:0] Load_len = 12'd0;
  logic        S_valid = 1'b0;
  logic [31:0] S_data = 32'h0;
  logic        S_ready;
  logic        IMEM_wr_en;
  logic [31:0] IMEM_wr_addr;
  logic [31:0] IMEM_wr_data;
  logic        Core_reset_n;
  logic        Load_busy;
  logic        Load_done;
  logic        Load_error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cyc_last = 0;

  logic [31:0] img [4];
  logic [31:0] img_sum;

  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          wq_cyc  [$];

  imem_loader #(.IMEM_DEPTH(2048), .LEN_WIDTH(12)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load_start(Load_start), .Load_len(Load_len),
    .S_valid(S_valid), .S_data(S_data), .S_ready(S_ready),
    .IMEM_wr_en(IMEM_wr_en), .IMEM_wr_addr(IMEM_wr_addr), .IMEM_wr_data(IMEM_wr_data),
    .Core_reset_n(Core_reset_n), .Load_busy(Load_busy), .Load_done(Load_done),
    .Load_error(Load_error)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Log every IMEM write seen mid-cycle.
  always @(negedge Clk) begin
    if (IMEM_wr_en === 1'b1) begin
      wq_addr.push_back(IMEM_wr_addr);
      wq_data.push_back(IMEM_wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic do_start(input logic [11:0] len);
    @(negedge Clk);
    Load_start = 1'b1;
    Load_len   = len;
    @(negedge Clk);
    Load_start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++; if (S_ready !== 1'b0)       begin n_errors++; $display("FAIL reset_s_ready got %b want 0", S_ready); end
    n_checks++; if (IMEM_wr_en !== 1'b0)    begin n_errors++; $display("FAIL reset_wr_en got %b want 0", IMEM_wr_en); end
    n_checks++; if (IMEM_wr_addr !== 32'h0) begin n_errors++; $display("FAIL reset_wr_addr got %h want 0", IMEM_wr_addr); end
    n_checks++; if (IMEM_wr_data !== 32'h0) begin n_errors++; $display("FAIL reset_wr_data got %h want 0", IMEM_wr_data); end
    n_checks++; if (Core_reset_n !== 1'b0)  begin n_errors++; $display("FAIL reset_core got %b want 0", Core_reset_n); end
    n_checks++; if (Load_busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy got %b want 0", Load_busy); end
    n_checks++; if (Load_done !== 1'b0)     begin n_errors++; $display("FAIL reset_done got %b want 0", Load_done); end
    n_checks++; if (Load_error !== 1'b0)    begin n_errors++; $display("FAIL reset_error got %b want 0", Load_error); end
    Reset_n = 1'b1;
    @(negedge Clk);
    n_checks++; if (S_ready !== 1'b0)       begin n_errors++; $display("FAIL idle_s_ready got %b want 0", S_ready); end
  endtask

  task automatic test_basic();
    clear_log();
    do_start(12'd4);
    n_checks++; if (S_ready !== 1'b1)      begin n_errors++; $display("FAIL basic_ready_after_start got %b want 1", S_ready); end
    n_checks++; if (Load_busy !== 1'b1)    begin n_errors++; $display("FAIL basic_busy got %b want 1", Load_busy); end
    for (int i = 0; i < 4; i++) begin
      S_valid = 1'b1;
      S_data  = img[i];
      @(negedge Clk);
    end
    S_valid  = 1'b0;
    cyc_last = cyc;
`ifdef LOADER_CHECKSUM_EN
    n_checks++; if (S_ready !== 1'b1) begin n_errors++; $display("FAIL basic_check_ready got %b want 1", S_ready); end
    S_valid = 1'b1;
    S_data  = img_sum;
    @(negedge Clk);
    S_valid = 1'b0;
`else
    n_checks++; if (Core_reset_n !== 1'b0) begin n_errors++; $display("FAIL basic_core_in_check got %b want 0", Core_reset_n); end
    n_checks++; if (S_ready !== 1'b0)      begin n_errors++; $display("FAIL basic_check_ready got %b want 0", S_ready); end
    @(negedge Clk);
`endif
    n_checks++; if (Core_reset_n !== 1'b1) begin n_errors++; $display("FAIL basic_core_run got %b want 1", Core_reset_n); end
    n_checks++; if (Load_done !== 1'b1)    begin n_errors++; $display("FAIL basic_done got %b want 1", Load_done); end
    n_checks++; if (Load_error !== 1'b0)   begin n_errors++; $display("FAIL basic_error got %b want 0", Load_error); end
    n_checks++; if (Load_busy !== 1'b0)    begin n_errors++; $display("FAIL basic_busy_run got %b want 0", Load_busy); end
    n_checks++; if (wq_addr.size() != 4)   begin n_errors++; $display("FAIL basic_write_count got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wq_addr.size()) begin
        n_checks++; if (wq_addr[i] !== 32'(i * 4)) begin n_errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, wq_addr[i], 32'(i * 4)); end
        n_checks++; if (wq_data[i] !== img[i])     begin n_errors++; $display("FAIL basic_data[%0d] got %h want %h", i, wq_data[i], img[i]); end
        n_checks++; if (wq_cyc[i] != cyc_last - 3 + i) begin n_errors++; $display("FAIL basic_cycle[%0d] got %0d want %0d", i, wq_cyc[i], cyc_last - 3 + i); end
      end
    end
  endtask

  task automatic test_gaps();
    clear_log();
    do_start(12'd4);
    n_checks++; if (Core_reset_n !== 1'b0) begin n_errors++; $display("FAIL gaps_core_falls got %b want 0", Core_reset_n); end
    n_checks++; if (Load_done !== 1'b0)    begin n_errors++; $display("FAIL gaps_done_falls got %b want 0", Load_done); end
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (Load_busy !== 1'b1) begin n_errors++; $display("FAIL gaps_busy[%0d] got %b want 1", k, Load_busy); end
      if ((k % 2) == 0) begin
        S_valid = 1'b1;
        S_data  = img[k / 2];
      end else begin
        S_valid = 1'b0;
        S_data  = 32'hDEAD_BEEF;
      end
      @(negedge Clk);
    end
    S_valid  = 1'b0;
    cyc_last = cyc;
    n_checks++; if (Load_busy !== 1'b1) begin n_errors++; $display("FAIL gaps_busy_check got %b want 1", Load_busy); end
`ifdef LOADER_CHECKSUM_EN
    S_valid = 1'b1;
    S_data  = img_sum;
    @(negedge Clk);
    S_valid = 1'b0;
`else
    @(negedge Clk);
`endif
    n_checks++; if (Core_reset_n !== 1'b1) begin n_errors++; $display("FAIL gaps_core_run got %b want 1", Core_reset_n); end
    n_checks++; if (wq_addr.size() != 4)   begin n_errors++; $display("FAIL gaps_write_count got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wq_addr.size()) begin
        n_checks++; if (wq_addr[i] !== 32'(i * 4)) begin n_errors++; $display("FAIL gaps_addr[%0d] got %h want %h", i, wq_addr[i], 32'(i * 4)); end
        n_checks++; if (wq_data[i] !== img[i])     begin n_errors++; $display("FAIL gaps_data[%0d] got %h want %h", i, wq_data[i], img[i]); end
        n_checks++; if (wq_cyc[i] != cyc_last - 6 + 2 * i) begin n_errors++; $display("FAIL gaps_cycle[%0d] got %0d want %0d", i, wq_cyc[i], cyc_last - 6 + 2 * i); end
      end
    end
  endtask

  task automatic test_oversize();
    clear_log();
    do_start(12'd2049);
    n_checks++; if (Load_error !== 1'b1)   begin n_errors++; $display("FAIL over_error got %b want 1", Load_error); end
    n_checks++; if (Core_reset_n !== 1'b0) begin n_errors++; $display("FAIL over_core got %b want 0", Core_reset_n); end
    n_checks++; if (Load_done !== 1'b0)    begin n_errors++; $display("FAIL over_done got %b want 0", Load_done); end
    n_checks++; if (Load_busy !== 1'b0)    begin n_errors++; $display("FAIL over_busy got %b want 0", Load_busy); end
    S_valid = 1'b1;
    S_data  = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      n_checks++; if (S_ready !== 1'b0)      begin n_errors++; $display("FAIL over_ready[%0d] got %b want 0", k, S_ready); end
      n_checks++; if (Core_reset_n !== 1'b0) begin n_errors++; $display("FAIL over_core_hold[%0d] got %b want 0", k, Core_reset_n); end
    end
    S_valid = 1'b0;
    @(negedge Clk);
    n_checks++; if (wq_addr.size() != 0)   begin n_errors++; $display("FAIL over_writes got %0d want 0", wq_addr.size()); end
    n_checks++; if (Load_error !== 1'b1)   begin n_errors++; $display("FAIL over_error_sticky got %b want 1", Load_error); end
  endtask

  task automatic test_len0();
    clear_log();
    do_start(12'd0);
    n_checks++; if (Load_error !== 1'b0)   begin n_errors++; $display("FAIL len0_error_cleared got %b want 0", Load_error); end
    n_checks++; if (Load_busy !== 1'b1)    begin n_errors++; $display("FAIL len0_busy got %b want 1", Load_busy); end
    n_checks++; if (Core_reset_n !== 1'b0) begin n_errors++; $display("FAIL len0_core_check got %b want 0", Core_reset_n); end
`ifdef LOADER_CHECKSUM_EN
    n_checks++; if (S_ready !== 1'b1) begin n_errors++; $display("FAIL len0_ready got %b want 1", S_ready); end
    S_valid = 1'b1;
    S_data  = 32'h0000_0000;
    @(negedge Clk);
    S_valid = 1'b0;
`else
    @(negedge Clk);
`endif
    n_checks++; if (Core_reset_n !== 1'b1) begin n_errors++; $display("FAIL len0_core_run got %b want 1", Core_reset_n); end
    n_checks++; if (Load_done !== 1'b1)    begin n_errors++; $display("FAIL len0_done got %b want 1", Load_done); end
    @(negedge Clk);
    n_checks++; if (wq_addr.size() != 0)   begin n_errors++; $display("FAIL len0_writes got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_mid_reset();
    clear_log();
    do_start(12'd8);
    for (int i = 0; i < 3; i++) begin
      S_valid = 1'b1;
      S_data  = img[i];
      @(negedge Clk);
    end
    S_valid = 1'b0;
    #2;
    n_checks++; if (wq_addr.size() != 3) begin n_errors++; $display("FAIL mid_partial_writes got %0d want 3", wq_addr.size()); end
    Reset_n = 1'b0;
    #1;
    n_checks++; if (S_ready !== 1'b0)       begin n_errors++; $display("FAIL mid_s_ready got %b want 0", S_ready); end
    n_checks++; if (IMEM_wr_en !== 1'b0)    begin n_errors++; $display("FAIL mid_wr_en got %b want 0", IMEM_wr_en); end
    n_checks++; if (IMEM_wr_addr !== 32'h0) begin n_errors++; $display("FAIL mid_wr_addr got %h want 0", IMEM_wr_addr); end
    n_checks++; if (IMEM_wr_data !== 32'h0) begin n_errors++; $display("FAIL mid_wr_data got %h want 0", IMEM_wr_data); end
    n_checks++; if (Core_reset_n !== 1'b0)  begin n_errors++; $display("FAIL mid_core got %b want 0", Core_reset_n); end
    n_checks++; if (Load_busy !== 1'b0)     begin n_errors++; $display("FAIL mid_busy got %b want 0", Load_busy); end
    n_checks++; if (Load_done !== 1'b0)     begin n_errors++; $display("FAIL mid_done got %b want 0", Load_done); end
    n_checks++; if (Load_error !== 1'b0)    begin n_errors++; $display("FAIL mid_error got %b want 0", Load_error); end
    @(negedge Clk);
    Reset_n = 1'b1;
    clear_log();
    do_start(12'd4);
    for (int i = 0; i < 4; i++) begin
      S_valid = 1'b1;
      S_data  = img[i];
      @(negedge Clk);
    end
`ifdef LOADER_CHECKSUM_EN
    S_data = img_sum;
    @(negedge Clk);
    S_valid = 1'b0;
`else
    S_valid = 1'b0;
    @(negedge Clk);
`endif
    n_checks++; if (Core_reset_n !== 1'b1) begin n_errors++; $display("FAIL mid_reload_run got %b want 1", Core_reset_n); end
    n_checks++; if (wq_addr.size() != 4)   begin n_errors++; $display("FAIL mid_reload_count got %0d want 4", wq_addr.size()); end
    if (wq_addr.size() == 4) begin
      n_checks++; if (wq_addr[0] !== 32'h0)  begin n_errors++; $display("FAIL mid_reload_addr0 got %h want 0", wq_addr[0]); end
      n_checks++; if (wq_data[0] !== img[0]) begin n_errors++; $display("FAIL mid_reload_data0 got %h want %h", wq_data[0], img[0]); end
      n_checks++; if (wq_addr[3] !== 32'hC)  begin n_errors++; $display("FAIL mid_reload_addr3 got %h want c", wq_addr[3]); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start(12'd2);
    S_valid = 1'b1; S_data = 32'h1; @(negedge Clk);
    S_data = 32'h2; @(negedge Clk);
    S_data = 32'h4; @(negedge Clk);
    S_valid = 1'b0;
    n_checks++; if (Load_error !== 1'b1)   begin n_errors++; $display("FAIL csum_bad_error got %b want 1", Load_error); end
    n_checks++; if (Core_reset_n !== 1'b0) begin n_errors++; $display("FAIL csum_bad_core got %b want 0", Core_reset_n); end
    n_checks++; if (Load_busy !== 1'b0)    begin n_errors++; $display("FAIL csum_bad_idle got %b want 0", Load_busy); end
    do_start(12'd2);
    n_checks++; if (Load_error !== 1'b0)   begin n_errors++; $display("FAIL csum_error_cleared got %b want 0", Load_error); end
    S_valid = 1'b1; S_data = 32'h1; @(negedge Clk);
    S_data = 32'h2; @(negedge Clk);
    S_data = 32'h3; @(negedge Clk);
    S_valid = 1'b0;
    n_checks++; if (Core_reset_n !== 1'b1) begin n_errors++; $display("FAIL csum_good_core got %b want 1", Core_reset_n); end
    n_checks++; if (Load_done !== 1'b1)    begin n_errors++; $display("FAIL csum_good_done got %b want 1", Load_done); end
    n_checks++; if (Load_error !== 1'b0)   begin n_errors++; $display("FAIL csum_good_error got %b want 0", Load_error); end
  endtask
`endif

  initial begin
    img[0]  = 32'h0000_0093;
    img[1]  = 32'h0010_0113;
    img[2]  = 32'h0020_81B3;
    img[3]  = 32'hC000_1073;
    img_sum = 32'hC030_93CC;
    test_reset();
    test_basic();
    test_gaps();
    test_oversize();
    test_len0();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Streaming program loader that sits directly upstream of the core's instruction memory. It accepts a word stream over a valid/ready handshake, writes it into IMEM at consecutive word-aligned byte addresses, and holds the core in reset until the image is complete. It then releases the core and reports done or error status.

## Interface
Parameters:
- IMEM_DEPTH, 2048, IMEM capacity in 32-bit words; power of two.
- LEN_WIDTH, 12, width of Load_len; must hold IMEM_DEPTH.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Load_start  in  1  single-cycle request to begin a load; sampled only in IDLE or RUN.
- Load_len  in  LEN_WIDTH  number of program words; sampled on an accepted Load_start.
- S_valid  in  1  stream word valid.
- S_data  in  32  stream word.
- S_ready  out  1  loader can accept S_data this cycle.
- IMEM_wr_en  out  1  one-cycle IMEM write strobe.
- IMEM_wr_addr  out  32  byte address, always word-aligned (bits [1:0] = 0).
- IMEM_wr_data  out  32  word to write.
- Core_reset_n  out  1  active-low reset to the core; low while not in RUN.
- Load_busy  out  1  high in LOAD and CHECK.
- Load_done  out  1  high in RUN.
- Load_error  out  1  sticky error; cleared by the next accepted Load_start.

## Operation
- States: IDLE, LOAD, CHECK, RUN.
- IDLE: S_ready = 0 and Core_reset_n = 0.
  - On Load_start with Load_len > IMEM_DEPTH: set Load_error and stay in IDLE.
  - On Load_start with Load_len = 0: go to CHECK.
  - Otherwise: latch Load_len, clear the word counter and running sum, and go to LOAD.
- LOAD: S_ready = 1. Each cycle with S_valid && S_ready is a beat.
  - On each beat, register an IMEM write: address = counter×4, data = S_data.
  - Increment the counter; add S_data to the 32-bit running sum, mod 2^32.
  - The beat with counter = Load_len−1 moves the FSM to CHECK.
- CHECK, with LOADER_CHECKSUM_EN: S_ready = 1 and the loader waits for one more beat.
  - If that word equals the running sum, go to RUN.
  - Otherwise set Load_error and go to IDLE.
  - This beat is never written to IMEM.
- CHECK, without LOADER_CHECKSUM_EN: S_ready = 0; go to RUN unconditionally on the next cycle.
- RUN: Core_reset_n = 1, Load_done = 1, S_ready = 0.
  - Load_start re-enters load handling exactly as in IDLE. Core_reset_n falls on the following edge, so the core is never running while IMEM is rewritten.
- Load_start in LOAD or CHECK is ignored.
- Stream words presented while S_ready = 0 are not consumed.

## Timing
- Reset values: S_ready 0, IMEM_wr_en 0, IMEM_wr_addr 0, IMEM_wr_data 0, Core_reset_n 0, Load_busy 0, Load_done 0, Load_error 0. FSM state is IDLE; counter and sum are 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Load_start accepted at edge N: state LOAD and S_ready = 1 from edge N+1.
- Beat at edge N: IMEM_wr_en = 1 with its address and data during cycle N+1, for exactly one cycle.
- Throughput: one word per cycle under continuous S_valid. Gaps in S_valid stall the loader without loss.
- Last data beat at edge N:
  - Without checksum: CHECK in N+1, RUN and Core_reset_n = 1 from N+2.
  - With checksum: the checksum beat at edge M gives RUN from M+1.
- The final IMEM write (cycle N+1) always completes before Core_reset_n rises.
- Reset_n assertion mid-load: every output returns to its reset value immediately (asynchronously). Partially written IMEM contents are left as-is; a new Load_start is required.

## Configuration
- LOADER_CHECKSUM_EN defined: a trailing checksum word is required after the image. A mismatch sets Load_error, returns to IDLE and keeps the core in reset.
- Macro undefined: no checksum word is consumed, the running-sum logic is removed, and Load_error is raised only by an oversize Load_len.

## Test plan
- Load_len = 4, continuous stream 0x00000093, 0x00100113, 0x002081b3, 0xc0001073 -> writes at addresses 0x0, 0x4, 0x8, 0xC in four consecutive cycles. Core_reset_n rises 2 cycles after the last beat; Load_done = 1, Load_error = 0.
- Same image with S_valid toggled every other cycle -> same four writes with identical addresses and data, no duplicated or dropped words, and Load_busy high throughout.
- Load_len = 0 -> no IMEM_wr_en pulse; RUN within 2 cycles without checksum, or after one checksum beat of 0x00000000 with it.
- Load_len = 2049 with IMEM_DEPTH = 2048 -> Load_error = 1, S_ready stays 0, Core_reset_n stays 0, no writes.
- With LOADER_CHECKSUM_EN: data 0x1, 0x2, checksum 0x4 -> Load_error = 1, FSM in IDLE, Core_reset_n = 0. Reload with checksum 0x3 -> RUN and Load_error cleared.
- Reset_n pulsed low after 3 of 8 beats -> all outputs at reset values the same cycle. A subsequent full load restarts writing at address 0x0.
